// File: rtl/pulse_monitor_if.sv
// Pulse line, result handshake and measurement fields between pulse_monitor
// and its consumer.
interface pulse_monitor_if #(
  parameter int WIDTH_W = 8,
  parameter int COUNT_W = 4
);
  logic               signal;
  logic               ack;
  logic               rise;
  logic               busy;
  logic               valid;
  logic [COUNT_W-1:0] count;
  logic [WIDTH_W-1:0] last_width;
  logic [WIDTH_W-1:0] max_width;
  logic               overflow;

  modport master (
    input  signal, ack,
    output rise, busy, valid, count, last_width, max_width, overflow
  );

  modport slave (
    output signal, ack,
    input  rise, busy, valid, count, last_width, max_width, overflow
  );
endinterface

// File: rtl/pulse_monitor.sv
// Samples an asynchronous pulse line and measures each burst: pulse count,
// last and longest high-width, reported through a valid/ack handshake.
//
// state | meaning
// IDLE  | waiting for the first rising edge of a burst
// HIGH  | line high, width counter running
// LOW   | line low inside a burst, gap counter running
// DONE  | result held, waiting for ack
module pulse_monitor #(
  parameter int WIDTH_W = 8,
  parameter int COUNT_W = 4,
  parameter int GAP     = 8
) (
  input  logic             clock,
  input  logic             reset,
  pulse_monitor_if.master  bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

  localparam logic [WIDTH_W-1:0] WMAX    = '1;
  localparam logic [COUNT_W-1:0] CMAX    = '1;
  localparam logic [WIDTH_W-1:0] GAP_END = WIDTH_W'(GAP - 1);

  state_t             state, state_nx;
  logic               s1, s2, s3;
  logic               rise_i;
  logic               rise;
  logic [WIDTH_W-1:0] width;
  logic [WIDTH_W-1:0] gap;
  logic [WIDTH_W-1:0] last_width;
  logic [WIDTH_W-1:0] max_width;
  logic [COUNT_W-1:0] count;
  logic               overflow;

  // s1/s2 resynchronise the line; s3 only serves edge detection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= bus.signal;
      s2   <= s1;
      s3   <= s2;
      rise <= rise_i;
    end
  end

  assign rise_i = s2 & ~s3;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (rise_i) state_nx = HIGH;
      HIGH: if (!s2) state_nx = LOW;
      LOW: begin
        if (rise_i)              state_nx = HIGH;
        else if (gap == GAP_END) state_nx = DONE;
      end
      DONE: if (bus.ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      width      <= '0;
      gap        <= '0;
      last_width <= '0;
      max_width  <= '0;
      count      <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise_i) begin
            count     <= COUNT_W'(1);
            width     <= WIDTH_W'(1);
            max_width <= '0;
            overflow  <= 1'b0;
          end
        end
        HIGH: begin
          if (s2) begin
            if (width == WMAX) overflow <= 1'b1;
            else               width    <= width + 1'b1;
          end else begin
            last_width <= width;
            max_width  <= (width > max_width) ? width : max_width;
            gap        <= WIDTH_W'(1);
          end
        end
        LOW: begin
          // a rising edge always beats the gap timeout
          if (rise_i) begin
            if (count == CMAX) overflow <= 1'b1;
            else               count    <= count + 1'b1;
            width <= WIDTH_W'(1);
          end else if (gap != GAP_END) begin
            gap <= gap + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rise       = rise;
  assign bus.busy       = (state == HIGH) || (state == LOW);
  assign bus.valid      = (state == DONE);
  assign bus.count      = count;
  assign bus.last_width = last_width;
  assign bus.max_width  = max_width;
  assign bus.overflow   = overflow;

endmodule
